bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before abort (used only when BRAM_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port res_n  input  1  reset, synchronous, active-high (asserted when 1).
REQ-005 SHALL have port req_read  input  NUM_PORTS  per-port read request, held until done.
REQ-006 SHALL have port req_write  input  NUM_PORTS  per-port write request, held until done.
REQ-007 SHALL have port req_addr  input  32*NUM_PORTS  per-port address; port i at bits [32i+31:32i].
REQ-008 SHALL have port req_wdata  input  32*NUM_PORTS  per-port write data, same packing.
REQ-009 SHALL have port req_done  output  NUM_PORTS  one-cycle completion pulse, one-hot.
REQ-010 SHALL have port req_rdata  output  32  read data, valid while req_done pulses.
REQ-011 SHALL have port req_err  output  1  timeout flag, valid while req_done pulses.
REQ-012 SHALL have port bram_addr, bram_wdata  output  32 each  latched address/data to bram.
REQ-013 SHALL have port bram_read, bram_write  output  1 each  bram strobes.
REQ-014 SHALL have port bram_rdata  input  32, bram_done  input  1  bram response.
REQ-015 SHALL have port grant_id  output  3  index of current/last granted port.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-018 IDLE: port i is requesting when req_read[i] or req_write[i]; if any, SHALL pick the winner round-robin starting at (last_grant+1) mod NUM_PORTS, latch addr/wdata/op, set grant_id, go ACCESS next cycle.
REQ-019 ACCESS: SHALL hold exactly one of bram_read/bram_write high with stable bram_addr/bram_wdata until the cycle bram_done=1; in that cycle capture bram_rdata, go RESP.
REQ-020 RESP: SHALL pulse req_done[grant_id] for exactly one cycle with captured req_rdata, update last_grant=grant_id, go IDLE.
REQ-021 Latency: request seen in IDLE at cycle t -> strobe at t+1 -> done pulse one cycle after bram_done; minimum 3 cycles with bram_done at t+1.
REQ-022 A port asserting both req_read and req_write SHALL be treated as write; req_rdata SHALL then be 0.
REQ-023 Requester SHALL deassert its request in the cycle after req_done; a request still high in IDLE after RESP SHALL count as a new request.
REQ-024 Request changes on non-granted ports during ACCESS/RESP SHALL NOT affect the transaction in flight.
REQ-025 bram_done seen in IDLE or RESP SHALL be ignored.
REQ-026 req_done, req_err, bram_read, bram_write SHALL be zero outside the states defined above.

Reset
REQ-027 On res_n=1 SHALL go IDLE; req_done=0, req_rdata=0, req_err=0, bram_* outputs=0, grant_id=0, busy=0, last_grant=NUM_PORTS-1 (so port 0 wins first).
REQ-028 Reset asserted mid-ACCESS SHALL drop bram strobes next cycle and abandon the transaction without req_done.

Configuration
REQ-029 Macro BRAM_ARB_TIMEOUT_EN defined: cycle counter cleared on ACCESS entry; if TIMEOUT cycles elapse without bram_done, SHALL drop strobe, go RESP, pulse req_done with req_err=1, req_rdata=0; a late bram_done SHALL be ignored.
REQ-030 Macro undefined: ACCESS waits indefinitely; req_err SHALL be constant 0; no counter logic.

Verification
REQ-031 Single read port 2, addr 0x100, bram_done 2 cycles after strobe returning 0xDEADBEEF -> req_done[2] pulse with req_rdata=0xDEADBEEF, grant_id=2.
REQ-032 Ports 0,1,3 request continuously after reset -> grant order 0,1,3,0,1,3; no port granted twice before others.
REQ-033 Port 1 asserts read and write, wdata 0x12345678 -> bram_write only, req_rdata=0.
REQ-034 Reset asserted during ACCESS of port 0 -> strobes 0 next cycle, no req_done, next grant goes to port 0.
REQ-035 BRAM_ARB_TIMEOUT_EN, TIMEOUT=8, bram_done never asserted -> req_done with req_err=1 after 8 ACCESS cycles; late bram_done ignored.
REQ-036 Non-granted port toggles req_addr during ACCESS -> bram_addr stays at latched value.

Source files
------------

// File: rtl/bram_arbiter.sv
// Round-robin arbiter granting NUM_PORTS requesters single-transaction access to one BRAM port.
// Optional access watchdog enabled by defining BRAM_ARB_TIMEOUT_EN.
module bram_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic [NUM_PORTS-1:0]    req_read,
  input  logic [NUM_PORTS-1:0]    req_write,
  input  logic [32*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    req_done,
  output logic [31:0]             req_rdata,
  output logic                    req_err,
  output logic [31:0]             bram_addr,
  output logic [31:0]             bram_wdata,
  output logic                    bram_read,
  output logic                    bram_write,
  input  logic [31:0]             bram_rdata,
  input  logic                    bram_done,
  output logic [2:0]              grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("bram_arbiter: NUM_PORTS must be 2..8 and TIMEOUT at least 1");
  end

  // Returns {found, index}: first requester after 'last', wrapping at NUM_PORTS.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [3:0] result;
    logic [3:0] cand;
    result = 4'd0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand   = {1'b0, last} + 4'(k);
      cand   = (cand >= 4'(NUM_PORTS)) ? cand - 4'(NUM_PORTS) : cand;
      result = req[cand[2:0]] ? {1'b1, cand[2:0]} : result;
    end
    return result;
  endfunction

  state_t                state_r, state_s;
  logic [2:0]            grant_id_r, grant_s;
  logic [2:0]            last_grant_r, last_s;
  logic                  op_write_r, wr_s;
  logic [31:0]           bram_addr_r, addr_s;
  logic [31:0]           bram_wdata_r, wdata_s;
  logic                  bram_read_r, rd_stb_s;
  logic                  bram_write_r, wr_stb_s;
  logic [NUM_PORTS-1:0]  req_done_r, done_s;
  logic [31:0]           req_rdata_r, rdata_s;
  logic                  busy_r, busy_s;

  logic [7:0]            req_any_s;
  logic [3:0]            pick_s;
  logic [7:0]            done_oh_full_s;
  logic [NUM_PORTS-1:0]  done_oh_s;
  logic [31:0]           sel_addr_s;
  logic [31:0]           sel_wdata_s;
  logic                  sel_write_s;

  assign req_any_s      = 8'(req_read | req_write);
  assign pick_s         = rr_pick(req_any_s, last_grant_r);
  assign done_oh_full_s = 8'd1 << grant_id_r;
  assign done_oh_s      = done_oh_full_s[NUM_PORTS-1:0];

`ifdef BRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_r;
  logic             req_err_r, err_s;

  // Access watchdog: counts ACCESS cycles, restarts whenever ACCESS is left.
  always_ff @(posedge clk) begin
    if (res_n) begin
      cnt_r <= '0;
    end else if (state_r == ACCESS) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end

  assign req_err = req_err_r;
`else
  assign req_err = 1'b0;
`endif

  // Mux the winning port's address, data and operation (write wins over read).
  always_comb begin
    sel_addr_s  = 32'd0;
    sel_wdata_s = 32'd0;
    sel_write_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_addr_s  = (3'(i) == pick_s[2:0]) ? req_addr[32*i +: 32]  : sel_addr_s;
      sel_wdata_s = (3'(i) == pick_s[2:0]) ? req_wdata[32*i +: 32] : sel_wdata_s;
      sel_write_s = (3'(i) == pick_s[2:0]) ? req_write[i]          : sel_write_s;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_id_r;
    last_s   = last_grant_r;
    wr_s     = op_write_r;
    addr_s   = bram_addr_r;
    wdata_s  = bram_wdata_r;
    rd_stb_s = 1'b0;
    wr_stb_s = 1'b0;
    done_s   = '0;
    rdata_s  = req_rdata_r;
    busy_s   = 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
    err_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_s  = ACCESS;
          grant_s  = pick_s[2:0];
          addr_s   = sel_addr_s;
          wdata_s  = sel_wdata_s;
          wr_s     = sel_write_s;
          rd_stb_s = ~sel_write_s;
          wr_stb_s = sel_write_s;
          busy_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        busy_s = 1'b1;
        if (bram_done) begin
          state_s = RESP;
          done_s  = done_oh_s;
          rdata_s = op_write_r ? 32'd0 : bram_rdata;
        end
`ifdef BRAM_ARB_TIMEOUT_EN
        else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          state_s = RESP;
          done_s  = done_oh_s;
          rdata_s = 32'd0;
          err_s   = 1'b1;
        end
`endif
        else begin
          rd_stb_s = ~op_write_r;
          wr_stb_s = op_write_r;
        end
      end
      RESP: begin
        state_s = IDLE;
        last_s  = grant_id_r;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (res_n) begin
      state_r      <= IDLE;
      grant_id_r   <= 3'd0;
      last_grant_r <= 3'(NUM_PORTS - 1);
      op_write_r   <= 1'b0;
      bram_addr_r  <= 32'd0;
      bram_wdata_r <= 32'd0;
      bram_read_r  <= 1'b0;
      bram_write_r <= 1'b0;
      req_done_r   <= '0;
      req_rdata_r  <= 32'd0;
      busy_r       <= 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
      req_err_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      grant_id_r   <= grant_s;
      last_grant_r <= last_s;
      op_write_r   <= wr_s;
      bram_addr_r  <= addr_s;
      bram_wdata_r <= wdata_s;
      bram_read_r  <= rd_stb_s;
      bram_write_r <= wr_stb_s;
      req_done_r   <= done_s;
      req_rdata_r  <= rdata_s;
      busy_r       <= busy_s;
`ifdef BRAM_ARB_TIMEOUT_EN
      req_err_r    <= err_s;
`endif
    end
  end

  assign req_done   = req_done_r;
  assign req_rdata  = req_rdata_r;
  assign bram_addr  = bram_addr_r;
  assign bram_wdata = bram_wdata_r;
  assign bram_read  = bram_read_r;
  assign bram_write = bram_write_r;
  assign grant_id   = grant_id_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter (4 ports, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bram_arbiter;

  logic         clk = 1'b0;
  logic         res_n;
  logic [3:0]   req_read, req_write, req_done;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  req_rdata, bram_addr, bram_wdata, bram_rdata;
  logic         req_err, bram_read, bram_write, bram_done, busy;
  logic [2:0]   grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  bram_arbiter #(.NUM_PORTS(4), .TIMEOUT(8)) dut (
    .clk(clk), .res_n(res_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_read(bram_read), .bram_write(bram_write),
    .bram_rdata(bram_rdata), .bram_done(bram_done),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    res_n = 1'b1;
    repeat (2) @(negedge clk);
    res_n = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b1; req_read = 4'd0; req_write = 4'd0;
    req_addr = 128'd0; req_wdata = 128'd0; bram_rdata = 32'd0; bram_done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (req_done !== 4'd0) begin n_fail++; $display("FAIL rst_done: got %b want 0000", req_done); end
    n_checks++; if (bram_read !== 1'b0 || bram_write !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got %b%b want 00", bram_read, bram_write); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    n_checks++; if (req_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", req_rdata); end
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", req_err); end
    n_checks++; if (bram_addr !== 32'd0 || bram_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_bram_bus: got %h/%h want 0/0", bram_addr, bram_wdata); end
    res_n = 1'b0;
  endtask

  task automatic test_single_read();
    req_read = 4'b0100; req_addr[95:64] = 32'h0000_0100;
    @(negedge clk);
    n_checks++; if (bram_read !== 1'b1 || bram_write !== 1'b0) begin n_fail++; $display("FAIL rd_strobe: got r%b w%b want r1 w0", bram_read, bram_write); end
    n_checks++; if (bram_addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %h want 100", bram_addr); end
    n_checks++; if (grant_id !== 3'd2) begin n_fail++; $display("FAIL rd_grant: got %0d want 2", grant_id); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b want 1", busy); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bram_read !== 1'b1 || req_done !== 4'd0) begin n_fail++; $display("FAIL rd_hold: got strobe %b done %b want 1/0000", bram_read, req_done); end
    bram_done = 1'b1; bram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL rd_done: got %b want 0100", req_done); end
    n_checks++; if (req_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", req_rdata); end
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", req_err); end
    n_checks++; if (bram_read !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_drop: got %b want 0", bram_read); end
    bram_done = 1'b0; req_read = 4'd0;
    @(negedge clk);
    n_checks++; if (req_done !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got done %b busy %b want 0000/0", req_done, busy); end
  endtask

  task automatic test_round_robin();
    int got[6];
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    int ng = 0;
    apply_reset();
    req_read = 4'b1011; bram_done = 1'b1;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (req_done !== 4'd0) begin
        for (int b = 0; b < 4; b++) if (req_done[b]) got[ng] = b;
        n_checks++; if ($countones(req_done) != 1) begin n_fail++; $display("FAIL rr_onehot: got %b want one-hot", req_done); end
        ng++;
      end
    end
    n_checks++; if (ng != 6) begin n_fail++; $display("FAIL rr_count: got %0d grants want 6", ng); end
    for (int i = 0; i < ng; i++) begin
      n_checks++; if (got[i] != exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got port %0d want %0d", i, got[i], exp_order[i]); end
    end
    req_read = 4'd0;
    repeat (3) @(negedge clk);
    bram_done = 1'b0;
  endtask

  task automatic test_read_write_both();
    apply_reset();
    req_read = 4'b0010; req_write = 4'b0010;
    req_addr[63:32] = 32'h0000_0040; req_wdata[63:32] = 32'h1234_5678;
    bram_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if (bram_write !== 1'b1 || bram_read !== 1'b0) begin n_fail++; $display("FAIL rw_strobe: got r%b w%b want r0 w1", bram_read, bram_write); end
    n_checks++; if (bram_wdata !== 32'h1234_5678 || bram_addr !== 32'h40) begin n_fail++; $display("FAIL rw_bus: got %h/%h want 40/12345678", bram_addr, bram_wdata); end
    n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL rw_grant: got %0d want 1", grant_id); end
    bram_done = 1'b1;
    @(negedge clk);
    n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL rw_done: got %b want 0010", req_done); end
    n_checks++; if (req_rdata !== 32'd0) begin n_fail++; $display("FAIL rw_rdata: got %h want 0", req_rdata); end
    bram_done = 1'b0; req_read = 4'd0; req_write = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    req_read = 4'b0101; req_addr[31:0] = 32'h0000_0200; req_addr[95:64] = 32'h0000_0222;
    @(negedge clk);
    n_checks++; if (grant_id !== 3'd0 || bram_read !== 1'b1) begin n_fail++; $display("FAIL rma_first: got grant %0d strobe %b want 0/1", grant_id, bram_read); end
    res_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bram_read !== 1'b0 || bram_write !== 1'b0) begin n_fail++; $display("FAIL rma_drop: got r%b w%b want 00", bram_read, bram_write); end
    n_checks++; if (req_done !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rma_nodone: got done %b busy %b want 0000/0", req_done, busy); end
    res_n = 1'b0;
    @(negedge clk);
    n_checks++; if (grant_id !== 3'd0 || bram_read !== 1'b1 || bram_addr !== 32'h200) begin n_fail++; $display("FAIL rma_regrant: got grant %0d strobe %b addr %h want 0/1/200", grant_id, bram_read, bram_addr); end
    bram_done = 1'b1;
    @(negedge clk);
    n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL rma_done: got %b want 0001", req_done); end
    req_read = 4'd0;
    @(negedge clk);
    bram_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nongranted_toggle();
    apply_reset();
    req_write = 4'b1000; req_addr[127:96] = 32'h0000_0300; req_wdata[127:96] = 32'hA5A5_A5A5;
    @(negedge clk);
    n_checks++; if (grant_id !== 3'd3 || bram_write !== 1'b1 || bram_addr !== 32'h300) begin n_fail++; $display("FAIL ng_first: got grant %0d w%b addr %h want 3/1/300", grant_id, bram_write, bram_addr); end
    req_read[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr[63:32] = 32'h0000_0111 + 32'(i * 16);
      @(negedge clk);
      n_checks++; if (bram_addr !== 32'h300 || bram_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ng_stable[%0d]: got %h/%h want 300/a5a5a5a5", i, bram_addr, bram_wdata); end
    end
    req_addr[63:32] = 32'h0000_01F0; bram_done = 1'b1;
    @(negedge clk);
    n_checks++; if (req_done !== 4'b1000 || grant_id !== 3'd3) begin n_fail++; $display("FAIL ng_done: got %b grant %0d want 1000/3", req_done, grant_id); end
    req_write = 4'd0; bram_done = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ng_idle: got busy %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (grant_id !== 3'd1 || bram_read !== 1'b1 || bram_addr !== 32'h1F0) begin n_fail++; $display("FAIL ng_next: got grant %0d r%b addr %h want 1/1/1f0", grant_id, bram_read, bram_addr); end
    bram_done = 1'b1;
    @(negedge clk);
    n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL ng_done2: got %b want 0010", req_done); end
    req_read = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_done !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: got done %b busy %b want 0000/0", req_done, busy); end
    bram_done = 1'b0;
  endtask

`ifdef BRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int strobes = 0;
    apply_reset();
    req_read = 4'b0100; bram_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_done !== 4'd0) break;
      if (bram_read === 1'b1) strobes++;
    end
    n_checks++; if (strobes != 8) begin n_fail++; $display("FAIL to_cycles: got %0d want 8", strobes); end
    n_checks++; if (req_done !== 4'b0100 || req_err !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b err %b want 0100/1", req_done, req_err); end
    n_checks++; if (req_rdata !== 32'd0 || bram_read !== 1'b0) begin n_fail++; $display("FAIL to_data: got %h strobe %b want 0/0", req_rdata, bram_read); end
    bram_done = 1'b1; req_read = 4'd0;
    @(negedge clk);
    n_checks++; if (req_done !== 4'd0 || busy !== 1'b0 || req_err !== 1'b0) begin n_fail++; $display("FAIL to_late: got done %b busy %b err %b want 0000/0/0", req_done, busy, req_err); end
    bram_done = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_write_both();
    test_reset_mid_access();
    test_nongranted_toggle();
`ifdef BRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
